// File: rtl/fp_execute_stage2_pkg.sv
// Shared types and constants for FP execute stage 2 and its neighbours.
package fp_execute_stage2_pkg;

  localparam int NUM_VECTOR_LANES = 16;
  localparam int THREADS_PER_CORE = 4;
  localparam int FP_ALIGN_WIDTH   = 34;  // 32-bit significand + guard + round

  typedef logic [$clog2(THREADS_PER_CORE)-1:0] local_thread_idx_t;
  typedef logic [NUM_VECTOR_LANES-1:0]         vector_mask_t;
  typedef logic [3:0]                          subcycle_t;
  typedef logic [31:0]                         scalar_t;

  typedef enum logic [2:0] {
    FPOP_ADD,
    FPOP_SUB,
    FPOP_MUL,
    FPOP_ITOF,
    FPOP_FTOI,
    IMUL_LO,
    IMUL_HI,
    FPOP_CMP
  } fp_op_t;

  typedef struct packed {
    logic        has_dest;
    logic        dest_is_vector;
    logic [4:0]  dest_reg;
    fp_op_t      op;
    logic [1:0]  mask_src;
  } decoded_instruction_t;

endpackage

// File: rtl/fp_execute_stage2_if.sv
// Stage-1 to stage-2 bus plus stage-2 outputs and writeback rollback.
interface fp_execute_stage2_if
  #(parameter int NUM_LANES = fp_execute_stage2_pkg::NUM_VECTOR_LANES);
  import fp_execute_stage2_pkg::*;

  logic                           wb_rollback_en;
  local_thread_idx_t              wb_rollback_thread_idx;

  logic                           fx1_instruction_valid;
  decoded_instruction_t           fx1_instruction;
  vector_mask_t                   fx1_mask_value;
  local_thread_idx_t              fx1_thread_idx;
  subcycle_t                      fx1_subcycle;
  logic [NUM_LANES-1:0]           fx1_result_inf;
  logic [NUM_LANES-1:0]           fx1_result_nan;
  logic [NUM_LANES-1:0]           fx1_equal;
  logic [NUM_LANES-1:0]           fx1_logical_subtract;
  logic [NUM_LANES-1:0]           fx1_add_result_sign;
  logic [NUM_LANES-1:0]           fx1_mul_underflow;
  logic [NUM_LANES-1:0]           fx1_mul_sign;
  logic [NUM_LANES-1:0][5:0]      fx1_ftoi_lshift;
  logic [NUM_LANES-1:0][5:0]      fx1_se_align_shift;
  logic [NUM_LANES-1:0][31:0]     fx1_significand_le;
  logic [NUM_LANES-1:0][31:0]     fx1_significand_se;
  logic [NUM_LANES-1:0][7:0]      fx1_add_exponent;
  logic [NUM_LANES-1:0][7:0]      fx1_mul_exponent;
  logic [NUM_LANES-1:0][31:0]     fx1_multiplicand;
  logic [NUM_LANES-1:0][31:0]     fx1_multiplier;

  logic                           fx2_instruction_valid;
  decoded_instruction_t           fx2_instruction;
  vector_mask_t                   fx2_mask_value;
  local_thread_idx_t              fx2_thread_idx;
  subcycle_t                      fx2_subcycle;
  logic [NUM_LANES-1:0]           fx2_result_inf;
  logic [NUM_LANES-1:0]           fx2_result_nan;
  logic [NUM_LANES-1:0]           fx2_equal;
  logic [NUM_LANES-1:0]           fx2_logical_subtract;
  logic [NUM_LANES-1:0]           fx2_add_result_sign;
  logic [NUM_LANES-1:0]           fx2_mul_underflow;
  logic [NUM_LANES-1:0]           fx2_mul_sign;
  logic [NUM_LANES-1:0][5:0]      fx2_ftoi_lshift;
  logic [NUM_LANES-1:0][31:0]     fx2_significand_le;
  logic [NUM_LANES-1:0][31:0]     fx2_significand_se;
  logic [NUM_LANES-1:0]           fx2_guard;
  logic [NUM_LANES-1:0]           fx2_round;
  logic [NUM_LANES-1:0]           fx2_sticky;
  logic [NUM_LANES-1:0][7:0]      fx2_add_exponent;
  logic [NUM_LANES-1:0][7:0]      fx2_mul_exponent;
  logic [NUM_LANES-1:0][63:0]     fx2_significand_product;

  // Upstream side: drives stage-1 results and rollback, observes stage 2.
  modport master (
    output wb_rollback_en, wb_rollback_thread_idx,
    output fx1_instruction_valid, fx1_instruction, fx1_mask_value, fx1_thread_idx,
           fx1_subcycle, fx1_result_inf, fx1_result_nan, fx1_equal,
           fx1_logical_subtract, fx1_add_result_sign, fx1_mul_underflow,
           fx1_mul_sign, fx1_ftoi_lshift, fx1_se_align_shift, fx1_significand_le,
           fx1_significand_se, fx1_add_exponent, fx1_mul_exponent,
           fx1_multiplicand, fx1_multiplier,
    input  fx2_instruction_valid, fx2_instruction, fx2_mask_value, fx2_thread_idx,
           fx2_subcycle, fx2_result_inf, fx2_result_nan, fx2_equal,
           fx2_logical_subtract, fx2_add_result_sign, fx2_mul_underflow,
           fx2_mul_sign, fx2_ftoi_lshift, fx2_significand_le, fx2_significand_se,
           fx2_guard, fx2_round, fx2_sticky, fx2_add_exponent, fx2_mul_exponent,
           fx2_significand_product
  );

  // Stage-2 side.
  modport slave (
    input  wb_rollback_en, wb_rollback_thread_idx,
    input  fx1_instruction_valid, fx1_instruction, fx1_mask_value, fx1_thread_idx,
           fx1_subcycle, fx1_result_inf, fx1_result_nan, fx1_equal,
           fx1_logical_subtract, fx1_add_result_sign, fx1_mul_underflow,
           fx1_mul_sign, fx1_ftoi_lshift, fx1_se_align_shift, fx1_significand_le,
           fx1_significand_se, fx1_add_exponent, fx1_mul_exponent,
           fx1_multiplicand, fx1_multiplier,
    output fx2_instruction_valid, fx2_instruction, fx2_mask_value, fx2_thread_idx,
           fx2_subcycle, fx2_result_inf, fx2_result_nan, fx2_equal,
           fx2_logical_subtract, fx2_add_result_sign, fx2_mul_underflow,
           fx2_mul_sign, fx2_ftoi_lshift, fx2_significand_le, fx2_significand_se,
           fx2_guard, fx2_round, fx2_sticky, fx2_add_exponent, fx2_mul_exponent,
           fx2_significand_product
  );

endinterface

// File: rtl/fp_execute_stage2_align.sv
// Single-lane significand alignment with guard/round/sticky extraction.
module fp_align_shift
  import fp_execute_stage2_pkg::*;
#(
  parameter int ALIGN_WIDTH = FP_ALIGN_WIDTH
) (
  input  logic [31:0] significand,
  input  logic [5:0]  shift,
  output logic [31:0] aligned,
  output logic        guard,
  output logic        round,
  output logic        sticky
);

  logic [ALIGN_WIDTH-1:0] work;
  logic [ALIGN_WIDTH-1:0] shifted;
  logic [ALIGN_WIDTH-1:0] lost_mask;

  // Shift the guard/round-extended significand; sticky collects every bit pushed past round.
  always_comb begin
    work                       = '0;
    work[ALIGN_WIDTH-1 -: 32]  = significand;
    shifted                    = work >> shift;
    // Shift counts at or beyond the vector width yield an all-ones mask.
    lost_mask                  = ~({ALIGN_WIDTH{1'b1}} << shift);
    aligned                    = shifted[ALIGN_WIDTH-1 -: 32];
    guard                      = shifted[1];
    round                      = shifted[0];
    sticky                     = |(work & lost_mask);
  end

endmodule

// File: rtl/fp_execute_stage2.sv
// FP execute stage 2: significand alignment, 32x32 product, control forwarding.
module fp_execute_stage2
  import fp_execute_stage2_pkg::*;
#(
  parameter int NUM_LANES   = NUM_VECTOR_LANES,
  parameter int ALIGN_WIDTH = FP_ALIGN_WIDTH
) (
  input logic                clk,
  input logic                reset,
  fp_execute_stage2_if.slave bus
);

  typedef struct packed {
    logic                       instruction_valid;
    decoded_instruction_t       instruction;
    vector_mask_t               mask_value;
    local_thread_idx_t          thread_idx;
    subcycle_t                  subcycle;
    logic [NUM_LANES-1:0]       result_inf;
    logic [NUM_LANES-1:0]       result_nan;
    logic [NUM_LANES-1:0]       equal;
    logic [NUM_LANES-1:0]       logical_subtract;
    logic [NUM_LANES-1:0]       add_result_sign;
    logic [NUM_LANES-1:0]       mul_underflow;
    logic [NUM_LANES-1:0]       mul_sign;
    logic [NUM_LANES-1:0][5:0]  ftoi_lshift;
    logic [NUM_LANES-1:0][31:0] significand_le;
    logic [NUM_LANES-1:0][31:0] significand_se;
    logic [NUM_LANES-1:0]       guard;
    logic [NUM_LANES-1:0]       round;
    logic [NUM_LANES-1:0]       sticky;
    logic [NUM_LANES-1:0][7:0]  add_exponent;
    logic [NUM_LANES-1:0][7:0]  mul_exponent;
    logic [NUM_LANES-1:0][63:0] significand_product;
  } stage_t;

  stage_t stage_d;
  stage_t stage_q;

  logic [NUM_LANES-1:0][31:0] aligned_se;
  logic [NUM_LANES-1:0]       align_guard;
  logic [NUM_LANES-1:0]       align_round;
  logic [NUM_LANES-1:0]       align_sticky;

  for (genvar lane = 0; lane < NUM_LANES; lane++) begin : g_lane
    fp_align_shift #(
      .ALIGN_WIDTH (ALIGN_WIDTH)
    ) u_align (
      .significand (bus.fx1_significand_se[lane]),
      .shift       (bus.fx1_se_align_shift[lane]),
      .aligned     (aligned_se[lane]),
      .guard       (align_guard[lane]),
      .round       (align_round[lane]),
      .sticky      (align_sticky[lane])
    );
  end

  // Next-state: squash on same-thread rollback, datapath captured unconditionally.
  always_comb begin
    stage_d                   = '0;
    stage_d.instruction_valid = bus.fx1_instruction_valid
                                && !(bus.wb_rollback_en
                                     && bus.wb_rollback_thread_idx == bus.fx1_thread_idx);
    stage_d.instruction       = bus.fx1_instruction;
    stage_d.mask_value        = bus.fx1_mask_value;
    stage_d.thread_idx        = bus.fx1_thread_idx;
    stage_d.subcycle          = bus.fx1_subcycle;
    stage_d.result_inf        = bus.fx1_result_inf;
    stage_d.result_nan        = bus.fx1_result_nan;
    stage_d.equal             = bus.fx1_equal;
    stage_d.logical_subtract  = bus.fx1_logical_subtract;
    stage_d.add_result_sign   = bus.fx1_add_result_sign;
    stage_d.mul_underflow     = bus.fx1_mul_underflow;
    stage_d.mul_sign          = bus.fx1_mul_sign;
    stage_d.ftoi_lshift       = bus.fx1_ftoi_lshift;
    stage_d.significand_le    = bus.fx1_significand_le;
    stage_d.significand_se    = aligned_se;
    stage_d.guard             = align_guard;
    stage_d.round             = align_round;
    stage_d.sticky            = align_sticky;
    stage_d.add_exponent      = bus.fx1_add_exponent;
    stage_d.mul_exponent      = bus.fx1_mul_exponent;
    for (int unsigned lane = 0; lane < NUM_LANES; lane++) begin
      stage_d.significand_product[lane] = {32'b0, bus.fx1_multiplicand[lane]}
                                          * {32'b0, bus.fx1_multiplier[lane]};
    end
  end

  // Pipeline register; synchronous reset clears everything, datapath included.
  always_ff @(posedge clk) begin
    if (reset) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign bus.fx2_instruction_valid   = stage_q.instruction_valid;
  assign bus.fx2_instruction         = stage_q.instruction;
  assign bus.fx2_mask_value          = stage_q.mask_value;
  assign bus.fx2_thread_idx          = stage_q.thread_idx;
  assign bus.fx2_subcycle            = stage_q.subcycle;
  assign bus.fx2_result_inf          = stage_q.result_inf;
  assign bus.fx2_result_nan          = stage_q.result_nan;
  assign bus.fx2_equal               = stage_q.equal;
  assign bus.fx2_logical_subtract    = stage_q.logical_subtract;
  assign bus.fx2_add_result_sign     = stage_q.add_result_sign;
  assign bus.fx2_mul_underflow       = stage_q.mul_underflow;
  assign bus.fx2_mul_sign            = stage_q.mul_sign;
  assign bus.fx2_ftoi_lshift         = stage_q.ftoi_lshift;
  assign bus.fx2_significand_le      = stage_q.significand_le;
  assign bus.fx2_significand_se      = stage_q.significand_se;
  assign bus.fx2_guard               = stage_q.guard;
  assign bus.fx2_round               = stage_q.round;
  assign bus.fx2_sticky              = stage_q.sticky;
  assign bus.fx2_add_exponent        = stage_q.add_exponent;
  assign bus.fx2_mul_exponent        = stage_q.mul_exponent;
  assign bus.fx2_significand_product = stage_q.significand_product;

endmodule

// File: tb/tb_fp_execute_stage2.sv
// Scoreboard bench for fp_execute_stage2: random plus directed stimulus, reference model.
module tb_fp_execute_stage2;
  import fp_execute_stage2_pkg::*;

  localparam int L  = NUM_VECTOR_LANES;
  localparam int IW = $bits(decoded_instruction_t);

  typedef struct packed {
    int                 due;
    logic               valid;
    logic [IW-1:0]      instr;
    logic [L-1:0]       mask;
    logic [1:0]         thread;
    logic [3:0]         subcycle;
    logic [L-1:0]       inf, nan, eq, lsub, asign, muf, msign;
    logic [L-1:0][5:0]  ftoi;
    logic [L-1:0][31:0] sig_le, sig_se;
    logic [L-1:0]       guard, rnd, sticky;
    logic [L-1:0][7:0]  add_exp, mul_exp;
    logic [L-1:0][63:0] product;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  exp_t q[$];
  exp_t mon_e;

  fp_execute_stage2_if bus ();

  fp_execute_stage2 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Alignment defined arithmetically: divide the 2-bit-extended value by 2^s,
  // sticky when the remainder is nonzero; everything is lost past 34 bits.
  task automatic align_ref(input logic [31:0] se, input int s,
                           output logic [31:0] a, output logic g, output logic r,
                           output logic st);
    longint unsigned w, quo, rem;
    w = longint'(se) * 4;
    if (s >= 34) begin
      a = '0; g = 1'b0; r = 1'b0; st = (se != 0);
    end else begin
      quo = w / (64'd1 << s);
      rem = w % (64'd1 << s);
      a   = 32'(quo / 4);
      g   = quo[1];
      r   = quo[0];
      st  = (rem != 0);
    end
  endtask

  // Record what the DUT must show after the coming clock edge.
  task automatic push_expected();
    exp_t e;
    longint unsigned p;
    e = '0;
    e.due = cyc + 1;
    if (!reset) begin
      e.valid    = bus.fx1_instruction_valid &&
                   !(bus.wb_rollback_en && bus.wb_rollback_thread_idx == bus.fx1_thread_idx);
      e.instr    = bus.fx1_instruction;
      e.mask     = bus.fx1_mask_value;
      e.thread   = bus.fx1_thread_idx;
      e.subcycle = bus.fx1_subcycle;
      e.inf      = bus.fx1_result_inf;
      e.nan      = bus.fx1_result_nan;
      e.eq       = bus.fx1_equal;
      e.lsub     = bus.fx1_logical_subtract;
      e.asign    = bus.fx1_add_result_sign;
      e.muf      = bus.fx1_mul_underflow;
      e.msign    = bus.fx1_mul_sign;
      for (int l = 0; l < L; l++) begin
        e.ftoi[l]    = bus.fx1_ftoi_lshift[l];
        e.sig_le[l]  = bus.fx1_significand_le[l];
        e.add_exp[l] = bus.fx1_add_exponent[l];
        e.mul_exp[l] = bus.fx1_mul_exponent[l];
        align_ref(bus.fx1_significand_se[l], int'(bus.fx1_se_align_shift[l]),
                  e.sig_se[l], e.guard[l], e.rnd[l], e.sticky[l]);
        p = longint'(bus.fx1_multiplicand[l]);
        p = p * longint'(bus.fx1_multiplier[l]);
        e.product[l] = p;
      end
    end
    q.push_back(e);
  endtask

  task automatic compare(input exp_t e);
    chk("valid",       64'(bus.fx2_instruction_valid), 64'(e.valid));
    chk("instruction", 64'(bus.fx2_instruction), 64'(e.instr));
    chk("mask",        64'(bus.fx2_mask_value), 64'(e.mask));
    chk("thread",      64'(bus.fx2_thread_idx), 64'(e.thread));
    chk("subcycle",    64'(bus.fx2_subcycle), 64'(e.subcycle));
    chk("result_inf",  64'(bus.fx2_result_inf), 64'(e.inf));
    chk("result_nan",  64'(bus.fx2_result_nan), 64'(e.nan));
    chk("equal",       64'(bus.fx2_equal), 64'(e.eq));
    chk("logical_sub", 64'(bus.fx2_logical_subtract), 64'(e.lsub));
    chk("add_sign",    64'(bus.fx2_add_result_sign), 64'(e.asign));
    chk("mul_uflow",   64'(bus.fx2_mul_underflow), 64'(e.muf));
    chk("mul_sign",    64'(bus.fx2_mul_sign), 64'(e.msign));
    chk("guard",       64'(bus.fx2_guard), 64'(e.guard));
    chk("round",       64'(bus.fx2_round), 64'(e.rnd));
    chk("sticky",      64'(bus.fx2_sticky), 64'(e.sticky));
    for (int l = 0; l < L; l++) begin
      chk($sformatf("ftoi[%0d]", l),    64'(bus.fx2_ftoi_lshift[l]), 64'(e.ftoi[l]));
      chk($sformatf("sig_le[%0d]", l),  64'(bus.fx2_significand_le[l]), 64'(e.sig_le[l]));
      chk($sformatf("sig_se[%0d]", l),  64'(bus.fx2_significand_se[l]), 64'(e.sig_se[l]));
      chk($sformatf("add_exp[%0d]", l), 64'(bus.fx2_add_exponent[l]), 64'(e.add_exp[l]));
      chk($sformatf("mul_exp[%0d]", l), 64'(bus.fx2_mul_exponent[l]), 64'(e.mul_exp[l]));
      chk($sformatf("product[%0d]", l), bus.fx2_significand_product[l], e.product[l]);
    end
  endtask

  // Monitor: away from the active edge, check every entry that has come due.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      mon_e = q.pop_front();
      chk("due_cycle", 64'(cyc), 64'(mon_e.due));
      compare(mon_e);
    end
  end

  task automatic randomize_inputs();
    logic [IW-1:0] ins;
    ins = IW'($urandom());
    bus.fx1_instruction_valid  = ($urandom_range(0, 3) != 0);
    bus.fx1_instruction        = ins;
    bus.fx1_mask_value         = L'($urandom());
    bus.fx1_thread_idx         = 2'($urandom());
    bus.fx1_subcycle           = 4'($urandom());
    bus.wb_rollback_en         = ($urandom_range(0, 2) == 0);
    bus.wb_rollback_thread_idx = 2'($urandom());
    bus.fx1_result_inf         = L'($urandom());
    bus.fx1_result_nan         = L'($urandom());
    bus.fx1_equal              = L'($urandom());
    bus.fx1_logical_subtract   = L'($urandom());
    bus.fx1_add_result_sign    = L'($urandom());
    bus.fx1_mul_underflow      = L'($urandom());
    bus.fx1_mul_sign           = L'($urandom());
    for (int l = 0; l < L; l++) begin
      bus.fx1_ftoi_lshift[l]    = 6'($urandom());
      bus.fx1_se_align_shift[l] = ($urandom_range(0, 3) == 0) ? 6'($urandom())
                                                              : 6'($urandom_range(0, 35));
      bus.fx1_significand_le[l] = $urandom();
      bus.fx1_significand_se[l] = $urandom() >> $urandom_range(0, 24);
      bus.fx1_add_exponent[l]   = 8'($urandom());
      bus.fx1_mul_exponent[l]   = 8'($urandom());
      bus.fx1_multiplicand[l]   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom();
      bus.fx1_multiplier[l]     = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom();
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    randomize_inputs();
    bus.fx1_instruction_valid = 1'b1;
    // Reset with a valid input present: outputs must come out all zero.
    step(); reset = 1'b1; randomize_inputs(); bus.fx1_instruction_valid = 1'b1; push_expected();
    step(); reset = 1'b1; randomize_inputs(); bus.fx1_instruction_valid = 1'b1; push_expected();

    // Directed alignment/product corners, same-thread rollback squash.
    step(); reset = 1'b0; randomize_inputs();
    bus.fx1_significand_se[0] = 32'h0080_0007; bus.fx1_se_align_shift[0] = 6'd3;
    bus.fx1_significand_se[1] = 32'h00FF_FFFF; bus.fx1_se_align_shift[1] = 6'd27;
    bus.fx1_significand_se[2] = 32'h00FF_FFFF; bus.fx1_se_align_shift[2] = 6'd32;
    bus.fx1_significand_se[3] = 32'h00AB_CDEF; bus.fx1_se_align_shift[3] = 6'd0;
    bus.fx1_significand_se[4] = 32'hFFFF_FFFF; bus.fx1_se_align_shift[4] = 6'd34;
    bus.fx1_significand_se[5] = 32'h0000_0003; bus.fx1_se_align_shift[5] = 6'd2;
    bus.fx1_significand_se[6] = 32'h0000_0000; bus.fx1_se_align_shift[6] = 6'd63;
    bus.fx1_multiplicand[0] = 32'h0080_0000; bus.fx1_multiplier[0] = 32'h0080_0000;
    bus.fx1_multiplicand[1] = 32'hFFFF_FFFF; bus.fx1_multiplier[1] = 32'hFFFF_FFFF;
    bus.fx1_instruction_valid = 1'b1; bus.fx1_thread_idx = 2'd2;
    bus.wb_rollback_en = 1'b1; bus.wb_rollback_thread_idx = 2'd2;
    push_expected();

    // Rollback of a different thread leaves validity alone.
    step(); randomize_inputs();
    bus.fx1_instruction_valid = 1'b1; bus.fx1_thread_idx = 2'd2;
    bus.wb_rollback_en = 1'b1; bus.wb_rollback_thread_idx = 2'd1;
    push_expected();

    for (int i = 0; i < 300; i++) begin
      step();
      randomize_inputs();
      reset = (i == 150);
      if (i == 150 || i == 151) bus.fx1_instruction_valid = 1'b1;
      if (i == 151) bus.wb_rollback_en = 1'b0;
      push_expected();
    end

    step();
    bus.fx1_instruction_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fp_execute_stage2.md
Name: fp_execute_stage2

Overview:
Second stage of the floating-point/integer-multiply pipeline, directly downstream of floating-point execute stage 1.
- Addition/conversion path: right-aligns the smaller-exponent significand by the stage-1 shift count and produces guard, round and sticky bits for rounding in stage 3.
- Multiply path: forms the full 64-bit unsigned product of multiplicand and multiplier.
- Forwards all control and exception flags with one cycle of latency and squashes on rollback.

Parameters:
NUM_LANES, 16, vector lane count; must equal the package constant NUM_VECTOR_LANES.
ALIGN_WIDTH, 34, width of the shift working vector: 32-bit significand plus guard and round bits.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
wb_rollback_en  in  1  rollback request from writeback
wb_rollback_thread_idx  in  local_thread_idx_t  thread being rolled back
fx1_instruction_valid  in  1  stage-1 valid
fx1_instruction  in  decoded_instruction_t  decoded instruction
fx1_mask_value  in  vector_mask_t  lane mask
fx1_thread_idx  in  local_thread_idx_t  issuing thread
fx1_subcycle  in  subcycle_t  subcycle
fx1_result_inf / fx1_result_nan / fx1_equal / fx1_logical_subtract / fx1_add_result_sign / fx1_mul_underflow / fx1_mul_sign  in  NUM_LANES each  per-lane flags
fx1_ftoi_lshift / fx1_se_align_shift  in  NUM_LANES x 6  shift counts
fx1_significand_le / fx1_significand_se  in  NUM_LANES x 32  significands
fx1_add_exponent / fx1_mul_exponent  in  NUM_LANES x 8  exponents
fx1_multiplicand / fx1_multiplier  in  NUM_LANES x 32  multiply operands
fx2_instruction_valid, fx2_instruction, fx2_mask_value, fx2_thread_idx, fx2_subcycle  out  as the fx1_ inputs  registered control
fx2_result_inf, fx2_result_nan, fx2_equal, fx2_logical_subtract, fx2_add_result_sign, fx2_mul_underflow, fx2_mul_sign  out  NUM_LANES each  registered flags
fx2_ftoi_lshift  out  NUM_LANES x 6  passthrough
fx2_significand_le  out  NUM_LANES x 32  passthrough
fx2_significand_se  out  NUM_LANES x 32  aligned smaller significand
fx2_guard / fx2_round / fx2_sticky  out  NUM_LANES each  rounding bits
fx2_add_exponent / fx2_mul_exponent  out  NUM_LANES x 8  passthrough
fx2_significand_product  out  NUM_LANES x 64  unsigned product

Behaviour:
- Latency is exactly 1 cycle. Every output is registered on the rising edge of clk. There is no stall input; the stage accepts a new input every cycle.
- Reset:
  - reset=1 at an edge clears every output register to 0, including datapath outputs and fx2_instruction.
  - Reset takes priority over everything else, including a valid input or a rollback in the same cycle.
  - Reset asserted mid-stream discards the in-flight instruction.
- Valid: fx2_instruction_valid <= fx1_instruction_valid && !(wb_rollback_en && wb_rollback_thread_idx == fx1_thread_idx).
  - A rollback of a different thread does not affect validity.
  - Datapath registers update every cycle regardless of valid. The downstream stage must qualify them with valid.
- Alignment, per lane, with s = fx1_se_align_shift:
  - Working vector W = {fx1_significand_se, 2'b00} (34 bits); result R = W >> s.
  - fx2_significand_se = R[33:2]; fx2_guard = R[1]; fx2_round = R[0].
  - fx2_sticky = OR of all W bits shifted out below R[0], i.e. W[s-1:0]; sticky is 0 when s <= 2.
  - s = 0 passes the significand through unchanged with guard = round = sticky = 0.
  - s >= 34 gives aligned = 0, guard = 0, round = 0, sticky = |significand_se. Shift counts of 32 (ftoi value < 1) and 27 (add clamp) follow the same rule.
- Multiply: fx2_significand_product = {32'b0, fx1_multiplicand} * {32'b0, fx1_multiplier}, unsigned, full 64 bits, no truncation.
- All other fx2_ signals are the corresponding fx1_ inputs delayed by one cycle.
- Lanes are fully independent. The mask value is not applied here; it only passes through.

Decomposition:
- The defines package already provides local_thread_idx_t, decoded_instruction_t, vector_mask_t, subcycle_t, scalar_t and NUM_VECTOR_LANES.
- Add a package constant FP_ALIGN_WIDTH = 34 so stage 3 can share it.
- One sub-module is natural: fp_align_shift. It is a single-lane combinational block taking a 32-bit significand and a 6-bit shift, and returning the aligned significand plus guard, round and sticky. It is instantiated once per lane in a generate loop.

Test Plan:
1. se=0x00800007, s=3 -> fx2_significand_se=0x00100000, guard=1, round=1, sticky=1, one cycle later.
2. se=0x00FFFFFF, s=27 -> aligned=0x00000000, guard=0, round=0, sticky=1. Same se with s=32 -> aligned 0, guard 0, round 0, sticky 1.
3. se=0x00ABCDEF, s=0 -> aligned=0x00ABCDEF, guard=0, round=0, sticky=0.
4. multiplicand=0x00800000, multiplier=0x00800000 -> product=0x0000400000000000. 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE00000001.
5. fx1 valid=1, thread 2, rollback_en=1 for thread 2 -> fx2_instruction_valid=0. Rollback for thread 1 -> valid=1 and flags/exponents forwarded unchanged.
6. Valid input with reset=1 in the same cycle -> next cycle all outputs 0. After reset release, the next valid input appears after exactly one cycle.
